// File: rtl/maze_pkg.sv
// -----------------------------------------------------------------------------
// maze_pkg
//   Shared definitions for the maze game: grid geometry, start/goal cells,
//   the player-controller FSM state type and the move-direction type.
//   The maze top, the wall ROM and the player controller all import this
//   package so the geometry is defined in exactly one place.
// -----------------------------------------------------------------------------
package maze_pkg;

  // Default maze geometry (cells), start/goal cells and counter width.
  localparam int unsigned GRID_W_DEF  = 16;
  localparam int unsigned GRID_H_DEF  = 12;
  localparam int unsigned COORD_W_DEF = 4;
  localparam int unsigned START_X_DEF = 0;
  localparam int unsigned START_Y_DEF = 0;
  localparam int unsigned GOAL_X_DEF  = 15;
  localparam int unsigned GOAL_Y_DEF  = 11;
  localparam int unsigned STEP_W_DEF  = 10;

  // Player-controller FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,   // waiting for a direction pulse
    READ  = 2'd1,   // wall read issued, data arrives next cycle
    CHECK = 2'd2,   // wall data valid, commit or reject the move
    WIN   = 2'd3    // goal reached; only restart/reset leaves
  } state_e;

  // Requested move direction after priority resolution.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,   // row - 1
    DIR_DOWN  = 2'd1,   // row + 1
    DIR_LEFT  = 2'd2,   // col - 1
    DIR_RIGHT = 2'd3    // col + 1
  } dir_e;

endpackage : maze_pkg

// File: rtl/maze_player_ctrl.sv
// -----------------------------------------------------------------------------
// maze_player_ctrl
//   Player-movement stage in front of the maze renderer. A one-cycle direction
//   pulse selects a target cell one step away; if the target lies inside the
//   grid, the wall memory is read (1-cycle latency) and the player moves there
//   unless the cell is a wall. Legal steps are counted (saturating) and
//   reaching the goal cell raises a sticky win flag.
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-low reset
//   btn_up/down/left/right
//                  one-cycle move pulses; priority up > down > left > right
//   restart        one-cycle pulse; return to the start cell from any state
//   wall_rd_en     one-cycle wall read strobe
//   wall_rd_x/y    wall read address (holds last value between reads)
//   wall_rd_data   1 = wall; valid the cycle after wall_rd_en
//   pos_x/pos_y    registered player position
//   step_cnt       legal moves taken, saturating at all-ones
//   busy           move in flight (READ and CHECK cycles)
//   win            goal reached, sticky until restart/reset
//
// Timing: pulse in cycle N -> wall_rd_en in N+1 -> wall_rd_data sampled in
// N+2 -> new position visible in N+3. Pulses outside IDLE are dropped.
// -----------------------------------------------------------------------------
module maze_player_ctrl
  import maze_pkg::*;
#(
  parameter int unsigned GRID_W  = GRID_W_DEF,
  parameter int unsigned GRID_H  = GRID_H_DEF,
  parameter int unsigned COORD_W = COORD_W_DEF,
  parameter int unsigned START_X = START_X_DEF,
  parameter int unsigned START_Y = START_Y_DEF,
  parameter int unsigned GOAL_X  = GOAL_X_DEF,
  parameter int unsigned GOAL_Y  = GOAL_Y_DEF,
  parameter int unsigned STEP_W  = STEP_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               restart,
  output logic               wall_rd_en,
  output logic [COORD_W-1:0] wall_rd_x,
  output logic [COORD_W-1:0] wall_rd_y,
  input  logic               wall_rd_data,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [STEP_W-1:0]  step_cnt,
  output logic               busy,
  output logic               win
);

  // Grid limits and special cells at coordinate width.
  localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] START_XC = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_YC = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] GOAL_XC  = COORD_W'(GOAL_X);
  localparam logic [COORD_W-1:0] GOAL_YC  = COORD_W'(GOAL_Y);
  localparam logic [STEP_W-1:0]  STEP_MAX = '1;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_e             state_q;
  logic [COORD_W-1:0] pos_x_q, pos_y_q;
  logic [COORD_W-1:0] rd_x_q,  rd_y_q;
  logic [STEP_W-1:0]  step_q;
  logic               rd_en_q;
  logic               busy_q;
  logic               win_q;

  // ---------------------------------------------------------------------------
  // Direction select and target computation
  // ---------------------------------------------------------------------------
  logic               req_any;
  dir_e               dir_d;
  logic [COORD_W-1:0] tgt_x_d, tgt_y_d;
  logic               tgt_ok_d;
  logic               goal_hit;

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    req_any  = btn_up | btn_down | btn_left | btn_right;
    dir_d    = DIR_RIGHT;
    tgt_x_d  = pos_x_q;
    tgt_y_d  = pos_y_q;
    tgt_ok_d = 1'b0;

    // Only the highest-priority pulse is evaluated; if it points off the
    // grid the whole request is dropped rather than falling through to a
    // lower-priority direction.
    if (btn_up)         dir_d = DIR_UP;
    else if (btn_down)  dir_d = DIR_DOWN;
    else if (btn_left)  dir_d = DIR_LEFT;
    else                dir_d = DIR_RIGHT;

    // Bounds are tested before the +/-1 so that wrap-around at the
    // coordinate width can never produce a false in-range target.
    unique case (dir_d)
      DIR_UP: begin
        tgt_y_d  = pos_y_q - 1'b1;
        tgt_ok_d = (pos_y_q != '0);
      end
      DIR_DOWN: begin
        tgt_y_d  = pos_y_q + 1'b1;
        tgt_ok_d = (pos_y_q < Y_MAX);
      end
      DIR_LEFT: begin
        tgt_x_d  = pos_x_q - 1'b1;
        tgt_ok_d = (pos_x_q != '0);
      end
      DIR_RIGHT: begin
        tgt_x_d  = pos_x_q + 1'b1;
        tgt_ok_d = (pos_x_q < X_MAX);
      end
    endcase

    tgt_ok_d = tgt_ok_d & req_any;
  end

  // The read address registers double as the latched target: they are
  // loaded with the target when the read is issued and hold until the next
  // accepted request, so CHECK can commit straight from them.
  assign goal_hit = (rd_x_q == GOAL_XC) && (rd_y_q == GOAL_YC);

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pos_x_q <= START_XC;
      pos_y_q <= START_YC;
      rd_x_q  <= '0;
      rd_y_q  <= '0;
      step_q  <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
    end else if (restart) begin
      // Restart wins over any button and abandons an in-flight read; the
      // read address simply keeps its last value.
      state_q <= IDLE;
      pos_x_q <= START_XC;
      pos_y_q <= START_YC;
      step_q  <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tgt_ok_d) begin
            rd_x_q  <= tgt_x_d;
            rd_y_q  <= tgt_y_d;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= READ;
          end
        end

        READ: begin
          rd_en_q <= 1'b0;
          state_q <= CHECK;
        end

        CHECK: begin
          busy_q <= 1'b0;
          if (!wall_rd_data) begin
            pos_x_q <= rd_x_q;
            pos_y_q <= rd_y_q;
            if (step_q != STEP_MAX) begin
              step_q <= step_q + 1'b1;
            end
          end
          // Win only on a move that actually lands on the goal; this keeps
          // win low out of reset even when the start cell is the goal.
          if (!wall_rd_data && goal_hit) begin
            win_q   <= 1'b1;
            state_q <= WIN;
          end else begin
            state_q <= IDLE;
          end
        end

        WIN: begin
          // Terminal until restart/reset; moves are ignored.
          win_q  <= 1'b1;
          busy_q <= 1'b0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // ---------------------------------------------------------------------------
  assign wall_rd_en = rd_en_q;
  assign wall_rd_x  = rd_x_q;
  assign wall_rd_y  = rd_y_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign step_cnt   = step_q;
  assign busy       = busy_q;
  assign win        = win_q;

endmodule : maze_player_ctrl
